// File: rtl/booth_product_accumulator_if.sv
// ---------------------------------------------------------------------------
// booth_product_accumulator_if
//   Bundles the product input stream and the block-sum output stream of the
//   Booth product accumulator.
//   master : the surrounding logic. It drives clear, prod_valid, prod and
//            sum_ready, and it observes prod_ready, sum_valid, sum and ovf.
//   slave  : the accumulator itself.
//   Signals:
//     clear      block abort/flush
//     prod_valid prod is valid this cycle
//     prod       signed product, PROD_W bits
//     prod_ready accumulator accepts prod this cycle
//     sum_valid  sum/ovf hold a completed block result
//     sum        signed block sum, ACC_W bits
//     ovf        the block overflowed ACC_W
//     sum_ready  consumer takes sum this cycle
// ---------------------------------------------------------------------------
interface booth_product_accumulator_if #(
  parameter int PROD_W = 8,
  parameter int ACC_W  = 12
);
  logic                     clear;
  logic                     prod_valid;
  logic signed [PROD_W-1:0] prod;
  logic                     prod_ready;
  logic                     sum_valid;
  logic signed [ACC_W-1:0]  sum;
  logic                     ovf;
  logic                     sum_ready;

  modport master (
    output clear, prod_valid, prod, sum_ready,
    input  prod_ready, sum_valid, sum, ovf
  );

  modport slave (
    input  clear, prod_valid, prod, sum_ready,
    output prod_ready, sum_valid, sum, ovf
  );
endinterface

// File: rtl/booth_product_accumulator.sv
// ---------------------------------------------------------------------------
// booth_product_accumulator
//   Sums BLOCK_LEN signed products from the Booth multiplier stage into one
//   signed block sum. The sum is presented with a valid/ready handshake and a
//   per-block overflow flag. No new products are taken while a result is
//   pending.
//   Ports:
//     i_clk  clock; all state updates on the rising edge
//     i_rst  synchronous reset, active-high; overrides every other input
//     bus    booth_product_accumulator_if.slave (clear, product stream in,
//            sum stream out)
//   Configuration macro: SATURATE_EN
//     When defined, each add clamps to the ACC_W signed range, and a clamp
//     sets the overflow flag. When undefined, adds wrap modulo 2**ACC_W and
//     a signed overflow still sets the flag.
// ---------------------------------------------------------------------------
module booth_product_accumulator #(
  parameter int PROD_W    = 8,
  parameter int ACC_W     = 12,
  parameter int BLOCK_LEN = 4,
  parameter int CNT_W     = 3
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  booth_product_accumulator_if.slave    bus
);

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLOCK_LEN - 1);
  localparam logic [ACC_W-1:0] ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};

  // Signed overflow of a + b: the operands share a sign and the sum's sign differs.
  function automatic logic add_ovf(
    input logic [ACC_W-1:0] a,
    input logic [ACC_W-1:0] b,
    input logic [ACC_W-1:0] s
  );
    return (a[ACC_W-1] == b[ACC_W-1]) && (s[ACC_W-1] != a[ACC_W-1]);
  endfunction

  state_t             r_state;
  state_t             w_next_state;
  logic [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_flag;
  logic               r_sum_valid;
  logic [ACC_W-1:0]   r_sum;
  logic               r_ovf;

  logic               w_prod_ready;
  logic               w_accept;
  logic               w_last;
  logic [ACC_W-1:0]   w_sext;
  logic [ACC_W-1:0]   w_raw;
  logic               w_raw_ovf;
  logic [ACC_W-1:0]   w_add;

  // The size cast of a signed operand sign-extends the product to ACC_W.
  assign w_sext    = ACC_W'(bus.prod);
  assign w_raw     = r_acc + w_sext;
  assign w_raw_ovf = add_ovf(r_acc, w_sext, w_raw);
  assign w_accept  = bus.prod_valid && w_prod_ready;
  assign w_last    = (r_cnt == CNT_LAST);

  // Selects the value written back by one add: wrapped or clamped.
  always_comb begin
    w_add = w_raw;
`ifdef SATURATE_EN
    if (w_raw_ovf) begin
      // Overflow direction follows the common operand sign.
      w_add = r_acc[ACC_W-1] ? ACC_MIN : ACC_MAX;
    end else begin
      w_add = w_raw;
    end
`else
    w_add = w_raw;
`endif
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_ACCUM;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; a clear flushes the block and returns to ACCUM.
  always_comb begin
    w_next_state = r_state;
    if (bus.clear) begin
      w_next_state = ST_ACCUM;
    end else begin
      case (r_state)
        ST_ACCUM: begin
          if (w_accept && w_last) begin
            w_next_state = ST_HOLD;
          end else begin
            w_next_state = ST_ACCUM;
          end
        end
        ST_HOLD: begin
          if (bus.sum_ready) begin
            w_next_state = ST_ACCUM;
          end else begin
            w_next_state = ST_HOLD;
          end
        end
        default: w_next_state = ST_ACCUM;
      endcase
    end
  end

  // Output logic: products are only taken in ACCUM, outside reset and clear.
  always_comb begin
    w_prod_ready = 1'b0;
    if ((r_state == ST_ACCUM) && !bus.clear && !i_rst) begin
      w_prod_ready = 1'b1;
    end else begin
      w_prod_ready = 1'b0;
    end
  end

  // Accumulator, counter, sticky overflow flag and the registered result.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_acc       <= {ACC_W{1'b0}};
      r_cnt       <= {CNT_W{1'b0}};
      r_flag      <= 1'b0;
      r_sum_valid <= 1'b0;
      r_sum       <= {ACC_W{1'b0}};
      r_ovf       <= 1'b0;
    end else if (bus.clear) begin
      // A pending result is dropped, but sum keeps its last value.
      r_acc       <= {ACC_W{1'b0}};
      r_cnt       <= {CNT_W{1'b0}};
      r_flag      <= 1'b0;
      r_sum_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_ACCUM: begin
          if (w_accept) begin
            if (w_last) begin
              r_sum       <= w_add;
              r_ovf       <= r_flag | w_raw_ovf;
              r_sum_valid <= 1'b1;
              r_acc       <= {ACC_W{1'b0}};
              r_cnt       <= {CNT_W{1'b0}};
              r_flag      <= 1'b0;
            end else begin
              r_acc  <= w_add;
              r_cnt  <= r_cnt + CNT_ONE;
              r_flag <= r_flag | w_raw_ovf;
            end
          end
        end
        ST_HOLD: begin
          if (bus.sum_ready) begin
            r_sum_valid <= 1'b0;
          end
        end
        default: begin
          r_sum_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.prod_ready = w_prod_ready;
  assign bus.sum_valid  = r_sum_valid;
  assign bus.sum        = r_sum;
  assign bus.ovf        = r_ovf;

endmodule

// File: tb/tb_booth_product_accumulator.sv
// ---------------------------------------------------------------------------
// tb_booth_product_accumulator
//   Directed bench for booth_product_accumulator. Unit a uses the default
//   ACC_W=12. Unit b uses ACC_W=8 for the overflow case.
// ---------------------------------------------------------------------------
module tb_booth_product_accumulator;
  logic i_clk;
  logic i_rst;
  int   checks;
  int   errors;

  booth_product_accumulator_if #(.PROD_W(8), .ACC_W(12)) a_if ();
  booth_product_accumulator_if #(.PROD_W(8), .ACC_W(8))  b_if ();

  booth_product_accumulator #(.PROD_W(8), .ACC_W(12), .BLOCK_LEN(4), .CNT_W(3)) u_a (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (a_if.slave)
  );

  booth_product_accumulator #(.PROD_W(8), .ACC_W(8), .BLOCK_LEN(4), .CNT_W(3)) u_b (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (b_if.slave)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Offers one product to unit a (sel=0) or unit b (sel=1) and checks it is ready.
  task automatic send(input bit sel, input int v);
    if (sel) begin
      b_if.prod_valid = 1'b1;
      b_if.prod       = 8'(v);
      #1;
      chk("b_prod_ready_send", 32'(b_if.prod_ready), 32'd1);
    end else begin
      a_if.prod_valid = 1'b1;
      a_if.prod       = 8'(v);
      #1;
      chk("a_prod_ready_send", 32'(a_if.prod_ready), 32'd1);
    end
    tick();
    a_if.prod_valid = 1'b0;
    b_if.prod_valid = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    i_rst = 1'b1;
    a_if.clear = 1'b0; a_if.prod_valid = 1'b0; a_if.prod = 8'sd0; a_if.sum_ready = 1'b0;
    b_if.clear = 1'b0; b_if.prod_valid = 1'b0; b_if.prod = 8'sd0; b_if.sum_ready = 1'b0;

    // 1: reset for two cycles, then release.
    tick();
    tick();
    i_rst = 1'b0;
    #1;
    chk("rst_sum_valid", 32'(a_if.sum_valid), 32'd0);
    chk("rst_sum", $signed(a_if.sum), 32'sd0);
    chk("rst_ovf", 32'(a_if.ovf), 32'd0);
    chk("rst_prod_ready", 32'(a_if.prod_ready), 32'd1);
    chk("rst_b_prod_ready", 32'(b_if.prod_ready), 32'd1);

    // 2: 10,-3,64,-56 back to back with sum_ready high -> 15, one-cycle pulse.
    a_if.sum_ready = 1'b1;
    send(1'b0, 10);
    send(1'b0, -3);
    send(1'b0, 64);
    chk("t2_no_early_valid", 32'(a_if.sum_valid), 32'd0);
    send(1'b0, -56);
    chk("t2_sum_valid", 32'(a_if.sum_valid), 32'd1);
    chk("t2_sum", $signed(a_if.sum), 32'sd15);
    chk("t2_ovf", 32'(a_if.ovf), 32'd0);
    chk("t2_hold_not_ready", 32'(a_if.prod_ready), 32'd0);
    tick();
    chk("t2_valid_drops", 32'(a_if.sum_valid), 32'd0);
    chk("t2_ready_again", 32'(a_if.prod_ready), 32'd1);

    // 3: 1,2,3,4 with sum_ready low for 5 cycles -> 10 held stable.
    a_if.sum_ready = 1'b0;
    send(1'b0, 1);
    send(1'b0, 2);
    send(1'b0, 3);
    send(1'b0, 4);
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_valid", 32'(a_if.sum_valid), 32'd1);
      chk("t3_hold_sum", $signed(a_if.sum), 32'sd10);
      chk("t3_hold_not_ready", 32'(a_if.prod_ready), 32'd0);
      tick();
    end
    a_if.sum_ready = 1'b1;
    #1;
    chk("t3_valid_until_edge", 32'(a_if.sum_valid), 32'd1);
    tick();
    chk("t3_valid_drops", 32'(a_if.sum_valid), 32'd0);
    chk("t3_sum_kept", $signed(a_if.sum), 32'sd10);

    // 4: 20,30, clear, then 1,1,1,1 -> 4 with no early pulse.
    send(1'b0, 20);
    send(1'b0, 30);
    a_if.clear = 1'b1;
    a_if.prod_valid = 1'b1;
    a_if.prod = 8'sd99;
    #1;
    chk("t4_clear_not_ready", 32'(a_if.prod_ready), 32'd0);
    tick();
    a_if.clear = 1'b0;
    a_if.prod_valid = 1'b0;
    chk("t4_clear_no_valid", 32'(a_if.sum_valid), 32'd0);
    send(1'b0, 1);
    chk("t4_no_valid_1", 32'(a_if.sum_valid), 32'd0);
    send(1'b0, 1);
    chk("t4_no_valid_2", 32'(a_if.sum_valid), 32'd0);
    send(1'b0, 1);
    chk("t4_no_valid_3", 32'(a_if.sum_valid), 32'd0);
    send(1'b0, 1);
    chk("t4_sum_valid", 32'(a_if.sum_valid), 32'd1);
    chk("t4_sum", $signed(a_if.sum), 32'sd4);
    chk("t4_ovf", 32'(a_if.ovf), 32'd0);
    tick();

    // 5: ACC_W=8 unit, 64,64,0,0 overflows; the next block is clean.
    b_if.sum_ready = 1'b1;
    send(1'b1, 64);
    send(1'b1, 64);
    send(1'b1, 0);
    send(1'b1, 0);
    chk("t5_sum_valid", 32'(b_if.sum_valid), 32'd1);
`ifdef SATURATE_EN
    chk("t5_sum_sat", $signed(b_if.sum), 32'sd127);
`else
    chk("t5_sum_wrap", $signed(b_if.sum), -32'sd128);
`endif
    chk("t5_ovf", 32'(b_if.ovf), 32'd1);
    tick();
    send(1'b1, 1);
    send(1'b1, 1);
    send(1'b1, 1);
    send(1'b1, 1);
    chk("t5_next_sum", $signed(b_if.sum), 32'sd4);
    chk("t5_next_ovf", 32'(b_if.ovf), 32'd0);
    tick();

    // 6: 5,5,5 then reset, then 2,2,2,2 -> 8.
    send(1'b0, 5);
    send(1'b0, 5);
    send(1'b0, 5);
    i_rst = 1'b1;
    #1;
    chk("t6_rst_not_ready", 32'(a_if.prod_ready), 32'd0);
    tick();
    chk("t6_rst_sum", $signed(a_if.sum), 32'sd0);
    chk("t6_rst_valid", 32'(a_if.sum_valid), 32'd0);
    i_rst = 1'b0;
    send(1'b0, 2);
    send(1'b0, 2);
    send(1'b0, 2);
    chk("t6_no_early_valid", 32'(a_if.sum_valid), 32'd0);
    send(1'b0, 2);
    chk("t6_sum_valid", 32'(a_if.sum_valid), 32'd1);
    chk("t6_sum", $signed(a_if.sum), 32'sd8);
    chk("t6_ovf", 32'(a_if.ovf), 32'd0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
